// File: rtl/window_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// window_fetch_ctrl
//
// Bus-master front end of the edge-detection pipeline. Walks every interior
// pixel of an IMG_W x IMG_H image. For each one it reads the 24-bit pixels
// that make up the 3x3 neighbourhood over an hready-handshaked bus. It hands
// the assembled window to the downstream filter, then writes the filter result
// back to the output region.
//
// Along a row only the new right-hand column is fetched; the window register
// slides left. At the start of each row all nine pixels are read.
//
// Ports
//   clk        in   1   system clock, rising edge
//   n_rst      in   1   asynchronous active-low reset
//   stop       in   1   1 = hold idle / abort frame, 0 = run
//   hrdata     in   32  read data {8'h0,B,G,R}, valid when hready=1
//   hready     in   1   current transfer completes on this edge
//   haddr      out  32  bus address, 0 = no transfer requested
//   hwrite     out  1   1 = write transfer, 0 = read
//   hwdata     out  32  write data {8'h0,result}
//   win_valid  out  1   window on win_data is valid
//   win_ready  in   1   filter accepts window
//   win_data   out  72  9 x 8-bit samples, row-major, top-left in [7:0]
//   res_valid  in   1   filter result valid
//   res_ready  out  1   block accepts a result (WAIT_RES only)
//   res_data   in   24  filter result pixel
//   done       out  1   frame complete, held until stop=1
//
// Build option
//   GRAY_CONV_EN  defined: sample = (R + 2*G + B) >> 2 (10-bit sum, 8-bit result)
//                 undefined: sample = green channel hrdata[15:8]
// -----------------------------------------------------------------------------
module window_fetch_ctrl #(
  parameter int unsigned IMG_W   = 428,
  parameter int unsigned IMG_H   = 428,
  parameter int unsigned RD_BASE = 1,
  parameter int unsigned WR_BASE = IMG_W * IMG_H + 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        stop,
  input  logic [31:0] hrdata,
  input  logic        hready,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [31:0] hwdata,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] win_data,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [23:0] res_data,
  output logic        done
);

  // Interior pixel counters only ever reach IMG-2, so clog2(IMG) bits suffice.
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 2);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 2);

  localparam logic [31:0] IMG_W32   = 32'(IMG_W);
  localparam logic [31:0] RD_BASE32 = 32'(RD_BASE);
  localparam logic [31:0] WR_BASE32 = 32'(WR_BASE);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_WIN_OUT  = 3'd2;
  localparam logic [2:0] ST_WAIT_RES = 3'd3;
  localparam logic [2:0] ST_WRITE    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  logic [2:0]      state_q,  state_d;
  logic [RW-1:0]   row_q,    row_d;
  logic [CW-1:0]   col_q,    col_d;
  // Offset of the pixel being fetched inside the 3x3 window.
  logic [1:0]      rd_row_q, rd_row_d;
  logic [1:0]      rd_col_q, rd_col_d;
  logic [8:0][7:0] win_q,    win_d;
  logic [23:0]     res_q,    res_d;
  logic [31:0]     haddr_q,  haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [31:0]     hwdata_q, hwdata_d;

  // ---------------------------------------------------------------------------
  // Sample extraction from the raw bus word.
  // ---------------------------------------------------------------------------
  logic [7:0] rd_sample;

`ifdef GRAY_CONV_EN
  logic [9:0] gray_sum;
  logic       unused_hrdata;

  assign gray_sum      = {2'b00, hrdata[7:0]} + {1'b0, hrdata[15:8], 1'b0}
                       + {2'b00, hrdata[23:16]};
  assign rd_sample     = gray_sum[9:2];
  assign unused_hrdata = ^hrdata[31:24];
`else
  logic unused_hrdata;

  assign rd_sample     = hrdata[15:8];
  assign unused_hrdata = ^{hrdata[31:16], hrdata[7:0]};
`endif

  // ---------------------------------------------------------------------------
  // Address generation and fetch bookkeeping.
  // ---------------------------------------------------------------------------
  logic [31:0] pix_row;
  logic [31:0] pix_col;
  logic [31:0] rd_addr;
  logic [31:0] wr_addr;
  logic [3:0]  win_idx;
  logic        first_col;
  logic        last_read;
  logic        bus_busy;

  // r >= 1 and c >= 1 always, so the -1 never underflows.
  assign pix_row = 32'(row_q) + 32'(rd_row_q) - 32'd1;
  assign pix_col = 32'(col_q) + 32'(rd_col_q) - 32'd1;
  assign rd_addr = RD_BASE32 + pix_row * IMG_W32 + pix_col;
  assign wr_addr = WR_BASE32 + 32'(row_q) * IMG_W32 + 32'(col_q);

  assign win_idx   = 4'(rd_row_q) * 4'd3 + 4'(rd_col_q);
  assign first_col = (col_q == COL_ONE);
  // Full reload ends at offset (2,2); a slide only fetches column 2.
  assign last_read = (rd_row_q == 2'd2) && (!first_col || rd_col_q == 2'd2);
  // A nonzero address means a transfer is outstanding on the bus.
  assign bus_busy  = (haddr_q != 32'd0);

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic go_idle;

    // NOTE: every variable gets a default first so no path can infer a latch.
    go_idle  = 1'b0;
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    rd_row_d = rd_row_q;
    rd_col_d = rd_col_q;
    win_d    = win_q;
    res_d    = res_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (!stop) begin
          state_d  = ST_FETCH;
          rd_row_d = 2'd0;
          rd_col_d = 2'd0;
        end
      end

      ST_FETCH: begin
        if (bus_busy) begin
          // An issued read always runs to completion, even under stop.
          if (hready) begin
            win_d[win_idx] = rd_sample;
            haddr_d        = 32'd0;
            if (stop) begin
              go_idle = 1'b1;
            end else if (last_read) begin
              state_d  = ST_WIN_OUT;
              rd_row_d = 2'd0;
              rd_col_d = 2'd0;
            end else if (first_col && rd_col_q != 2'd2) begin
              rd_col_d = rd_col_q + 2'd1;
            end else begin
              rd_row_d = rd_row_q + 2'd1;
              if (first_col) begin
                rd_col_d = 2'd0;
              end
            end
          end
        end else if (stop) begin
          go_idle = 1'b1;
        end else begin
          // haddr was 0 for the preceding cycle, so the bus gap is honoured.
          haddr_d = rd_addr;
        end
      end

      ST_WIN_OUT: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (win_ready) begin
          state_d = ST_WAIT_RES;
        end
      end

      ST_WAIT_RES: begin
        if (stop) begin
          go_idle = 1'b1;
        end else if (res_valid) begin
          res_d   = res_data;
          state_d = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (bus_busy) begin
          if (hready) begin
            haddr_d  = 32'd0;
            hwrite_d = 1'b0;
            hwdata_d = 32'd0;
            if (stop) begin
              go_idle = 1'b1;
            end else if (col_q != COL_LAST) begin
              // Same row: slide the window left, then fetch only column 2.
              col_d    = col_q + COL_ONE;
              rd_row_d = 2'd0;
              rd_col_d = 2'd2;
              for (int i = 0; i < 3; i++) begin
                win_d[3*i]   = win_q[3*i+1];
                win_d[3*i+1] = win_q[3*i+2];
              end
              state_d = ST_FETCH;
            end else if (row_q != ROW_LAST) begin
              row_d    = row_q + ROW_ONE;
              col_d    = COL_ONE;
              rd_row_d = 2'd0;
              rd_col_d = 2'd0;
              state_d  = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end
        end else if (stop) begin
          go_idle = 1'b1;
        end else begin
          haddr_d  = wr_addr;
          hwrite_d = 1'b1;
          hwdata_d = {8'h00, res_q};
        end
      end

      ST_DONE: begin
        if (stop) begin
          go_idle = 1'b1;
        end
      end

      default: begin
        go_idle = 1'b1;
      end
    endcase

    // Every abort path funnels through here so counters restart cleanly.
    if (go_idle) begin
      state_d  = ST_IDLE;
      row_d    = ROW_ONE;
      col_d    = COL_ONE;
      rd_row_d = 2'd0;
      rd_col_d = 2'd0;
      haddr_d  = 32'd0;
      hwrite_d = 1'b0;
      hwdata_d = 32'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      row_q    <= ROW_ONE;
      col_q    <= COL_ONE;
      rd_row_q <= 2'd0;
      rd_col_q <= 2'd0;
      // NOTE: the window store is reset because win_data must read zero out of reset.
      win_q    <= '0;
      res_q    <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      rd_row_q <= rd_row_d;
      rd_col_q <= rd_col_d;
      win_q    <= win_d;
      res_q    <= res_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs.
  // ---------------------------------------------------------------------------
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign win_data  = win_q;
  assign win_valid = (state_q == ST_WIN_OUT);
  assign res_ready = (state_q == ST_WAIT_RES);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_window_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_window_fetch_ctrl
//
// Directed bench for window_fetch_ctrl on a 5x4 image. The stimulus process
// pushes the expected bus transfers and windows for each frame into queues.
// A separate monitor pops and compares entries whenever the DUT completes a
// transfer or hands over a window. A memory model answers every transfer one
// cycle after haddr goes nonzero. It can be held off to exercise the abort path.
// -----------------------------------------------------------------------------
module tb_window_fetch_ctrl;

  localparam int unsigned IMG_W   = 5;
  localparam int unsigned IMG_H   = 4;
  localparam int unsigned RD_BASE = 1;
  localparam int unsigned WR_BASE = IMG_W * IMG_H + 1;
  localparam int          NPIX    = IMG_W * IMG_H;

  logic        clk;
  logic        n_rst;
  logic        stop;
  logic [31:0] hrdata;
  logic        hready;
  logic [31:0] haddr;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        win_valid;
  logic        win_ready;
  logic [71:0] win_data;
  logic        res_valid;
  logic        res_ready;
  logic [23:0] res_data;
  logic        done;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  bus_t        exp_bus[$];
  logic [71:0] exp_win[$];
  logic [31:0] mem [0:NPIX];
  logic        mem_hold;
  int          n_tests;
  int          n_fail;
  int          n_writes;

  window_fetch_ctrl #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .RD_BASE (RD_BASE),
    .WR_BASE (WR_BASE)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .stop      (stop),
    .hrdata    (hrdata),
    .hready    (hready),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hwdata    (hwdata),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference sample derived from a raw memory word.
  function automatic logic [7:0] samp(input logic [31:0] w);
`ifdef GRAY_CONV_EN
    int s;
    s = int'(w[7:0]) + 2 * int'(w[15:8]) + int'(w[23:16]);
    return 8'(s / 4);
`else
    return w[15:8];
`endif
  endfunction

  function automatic int pix_addr(input int r, input int c);
    return int'(RD_BASE) + r * int'(IMG_W) + c;
  endfunction

  // Wait one cycle and return #1 after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected reads, windows and writes for one whole frame, in order.
  task automatic push_frame();
    bus_t        b;
    logic [71:0] w;
    for (int r = 1; r <= int'(IMG_H) - 2; r++) begin
      for (int c = 1; c <= int'(IMG_W) - 2; c++) begin
        for (int rr = 0; rr < 3; rr++) begin
          if (c == 1) begin
            for (int cc = 0; cc < 3; cc++) begin
              b = '{wr: 1'b0, addr: 32'(pix_addr(r - 1 + rr, cc)), data: 32'h0};
              exp_bus.push_back(b);
            end
          end else begin
            b = '{wr: 1'b0, addr: 32'(pix_addr(r - 1 + rr, c + 1)), data: 32'h0};
            exp_bus.push_back(b);
          end
        end
        w = '0;
        for (int rr = 0; rr < 3; rr++) begin
          for (int cc = 0; cc < 3; cc++) begin
            w[8*(rr*3+cc) +: 8] = samp(mem[pix_addr(r - 1 + rr, c - 1 + cc)]);
          end
        end
        exp_win.push_back(w);
        b = '{wr: 1'b1,
              addr: 32'(int'(WR_BASE) + r * int'(IMG_W) + c),
              data: {8'h00, 24'hABCDEF + 24'(samp(mem[pix_addr(r, c)])) - 24'h000011}};
        exp_bus.push_back(b);
      end
    end
  endtask

  task automatic run_frame(input string tag);
    int cyc;
    int w0;
    w0   = n_writes;
    cyc  = 0;
    stop = 1'b0;
    while (done !== 1'b1 && cyc < 2000) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_writes"}, 72'(n_writes - w0), 72'd6);
    check({tag, "_bus_left"}, 72'(exp_bus.size()), 72'd0);
    check({tag, "_win_left"}, 72'(exp_win.size()), 72'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Memory model: answers one cycle after haddr goes nonzero unless held off.
  // ---------------------------------------------------------------------------
  initial begin
    hready = 1'b0;
    hrdata = 32'h0;
    forever begin
      @(negedge clk);
      if (haddr != 32'd0 && !mem_hold) begin
        hready = 1'b1;
        hrdata = (!hwrite && haddr <= 32'(NPIX)) ? mem[haddr[4:0]] : 32'hDEAD_BEEF;
      end else begin
        hready = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares completed transfers and accepted windows in order; the
  // filter stub answers each window with a result derived from its centre.
  // ---------------------------------------------------------------------------
  initial begin
    bus_t        e;
    logic [71:0] w;
    res_data = 24'h0;
    forever begin
      @(negedge clk);
      #1;
      if (n_rst && haddr != 32'd0 && hready) begin
        if (exp_bus.size() == 0) begin
          check("bus_unexpected", haddr, 72'd0);
        end else begin
          e = exp_bus.pop_front();
          check("bus_addr", haddr, e.addr);
          check("bus_hwrite", hwrite, e.wr);
          if (e.wr) begin
            check("bus_hwdata", hwdata, e.data);
            n_writes++;
          end
        end
      end
      if (n_rst && win_valid && win_ready) begin
        if (exp_win.size() == 0) begin
          check("win_unexpected", win_data, 72'd0);
        end else begin
          w = exp_win.pop_front();
          check("win_data", win_data, w);
        end
        res_data = 24'hABCDEF + 24'(win_data[39:32]) - 24'h000011;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus.
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    n_tests   = 0;
    n_fail    = 0;
    n_writes  = 0;
    n_rst     = 1'b0;
    stop      = 1'b1;
    win_ready = 1'b1;
    res_valid = 1'b1;
    mem_hold  = 1'b0;
    for (int i = 0; i <= NPIX; i++) mem[i] = 32'h0;
    for (int r = 0; r < int'(IMG_H); r++) begin
      for (int c = 0; c < int'(IMG_W); c++) begin
        logic [7:0] g;
        g = {4'(r), 4'(c)};
        mem[pix_addr(r, c)] = {8'h00, g, g, g};
      end
    end

    // Reset values.
    #3;
    check("rst_haddr", haddr, 72'd0);
    check("rst_hwrite", hwrite, 72'd0);
    check("rst_hwdata", hwdata, 72'd0);
    check("rst_win_valid", win_valid, 72'd0);
    check("rst_win_data", win_data, 72'd0);
    check("rst_res_ready", res_ready, 72'd0);
    check("rst_done", done, 72'd0);
    tick();
    tick();
    n_rst = 1'b1;

    // stop=1 keeps the block idle.
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_haddr", haddr, 72'd0);
    end

    // Frame 1 with the first window stalled by win_ready=0.
    win_ready = 1'b0;
    push_frame();
    stop = 1'b0;
    cyc  = 0;
    while (win_valid !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      check("stall_win_valid", win_valid, 72'd1);
      check("stall_win_data", win_data, 72'h22_21_20_12_11_10_02_01_00);
      tick();
    end
    win_ready = 1'b1;
    run_frame("f1");

    // done is held while stop=0, cleared by stop=1.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold", done, 72'd1);
      check("done_haddr", haddr, 72'd0);
    end
    stop = 1'b1;
    tick();
    check("done_clear", done, 72'd0);
    tick();

    // Abort while the read of address 6 waits for hready.
    for (int a = 1; a <= 6; a++) begin
      if (a == 1 || a == 2 || a == 3 || a == 6) begin
        exp_bus.push_back('{wr: 1'b0, addr: 32'(a), data: 32'h0});
      end
    end
    stop = 1'b0;
    cyc  = 0;
    while (haddr !== 32'd6 && cyc < 200) begin
      tick();
      cyc++;
    end
    mem_hold = 1'b1;
    stop     = 1'b1;
    check("abort_addr_seen", haddr, 72'd6);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_haddr_held", haddr, 72'd6);
    end
    mem_hold = 1'b0;
    tick();
    check("abort_idle_haddr", haddr, 72'd0);
    check("abort_win_valid", win_valid, 72'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_bus", haddr, 72'd0);
    end
    check("abort_bus_left", 72'(exp_bus.size()), 72'd0);

    // Restart must re-read from address 1.
    push_frame();
    run_frame("f2");
    stop = 1'b1;
    tick();
    tick();

    // Frame with conversion test vectors in the top-left pixels.
    mem[1] = 32'h0040_80C0;
    mem[2] = 32'h00FF_00FF;
    push_frame();
    run_frame("f3");
    stop = 1'b1;
    tick();
    tick();

    // Asynchronous reset mid-FETCH.
    stop = 1'b0;
    cyc  = 0;
    while (haddr === 32'd0 && cyc < 50) begin
      tick();
      cyc++;
    end
    check("rst_mid_addr", haddr, 72'd1);
    #1;
    n_rst = 1'b0;
    #1;
    check("rst_mid_haddr", haddr, 72'd0);
    check("rst_mid_win_valid", win_valid, 72'd0);
    check("rst_mid_done", done, 72'd0);
    stop = 1'b1;
    tick();
    n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_after_haddr", haddr, 72'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
